// File: rtl/ahb_gpio_slave.sv
// AHB-Lite GPIO slave: DATA/DIRM/OEN registers, LED outputs, synchronized key inputs; zero-wait OKAY, two-cycle ERROR.
// Read data registered at accept (1-cycle latency); define GPIO_DEBOUNCE_EN to add per-bit input debounce.
module ahb_gpio_slave #(
   parameter int                GPIO_W          = 8,
   parameter logic [GPIO_W-1:0] IN_RESET_VAL    = 8'hFF,
   parameter int                DEBOUNCE_CYCLES = 500_000
) (
   input  logic              iHCLK,
   input  logic              iHRESET,
   input  logic              iHSEL,
   input  logic [31:0]       iHADDR,
   input  logic [1:0]        iHTRANS,
   input  logic              iHWRITE,
   input  logic [2:0]        iHSIZE,
   input  logic [31:0]       iHWDATA,
   input  logic              iHREADY,
   output logic              oHREADYOUT,
   output logic [31:0]       oHRDATA,
   output logic [1:0]        oHRESP,
   input  logic [GPIO_W-1:0] iGPIO_IN,
   output logic [GPIO_W-1:0] oGPIO_OUT,
   output logic [GPIO_W-1:0] oGPIO_OE
);

   typedef enum logic [1:0] {ACCESS, ERR1, ERR2} state_t;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   state_t            state;
   logic [GPIO_W-1:0] data_q, dirm_q, oen_q;
   logic [GPIO_W-1:0] data_nx, dirm_nx, oen_nx;
   logic              wr_pend;
   logic [1:0]        wr_sel;
   logic [GPIO_W-1:0] sync_a, sync_b, pin_val;
   logic [7:0]        off;
   logic              accept, addr_ok, bad;
   logic [GPIO_W-1:0] rd_bits;
   logic [31:0]       rd_val;
   logic              unused_ok;

   // Two-flop synchronizer for the asynchronous key pins.
   always_ff @(posedge iHCLK) begin
      if (iHRESET) begin
         sync_a <= IN_RESET_VAL;
         sync_b <= IN_RESET_VAL;
      end else begin
         sync_a <= iGPIO_IN;
         sync_b <= sync_a;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0]  deb_cnt [GPIO_W];
   logic [GPIO_W-1:0] deb_val;

   // A bit flips only after disagreeing for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge iHCLK) begin
      if (iHRESET) begin
         deb_val <= IN_RESET_VAL;
         for (int i = 0; i < GPIO_W; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < GPIO_W; i++) begin
            if (sync_b[i] == deb_val[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == CNT_LAST) begin
               deb_val[i] <= sync_b[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign pin_val = deb_val;
`else
   logic unused_cfg;
   assign unused_cfg = DEBOUNCE_CYCLES[0];
   assign pin_val    = sync_b;
`endif

   assign off     = iHADDR[7:0];
   assign accept  = iHSEL & iHTRANS[1] & iHREADY & oHREADYOUT;
   assign addr_ok = (off == 8'h00) || (off == 8'h04) || (off == 8'h08) || (off == 8'h0C);
   assign bad     = !addr_ok || (iHWRITE && (off == 8'h00));

   // Register values as of the end of the current data phase; reads use these to forward.
   always_comb begin
      data_nx = data_q;
      dirm_nx = dirm_q;
      oen_nx  = oen_q;
      if (wr_pend) begin
         case (wr_sel)
            2'd1:    data_nx = iHWDATA[GPIO_W-1:0];
            2'd2:    dirm_nx = iHWDATA[GPIO_W-1:0];
            2'd3:    oen_nx  = iHWDATA[GPIO_W-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_bits = '0;
      case (off)
         8'h00:   rd_bits = pin_val;
         8'h04:   rd_bits = (dirm_nx & data_nx) | (~dirm_nx & pin_val);
         8'h08:   rd_bits = dirm_nx;
         8'h0C:   rd_bits = oen_nx;
         default: rd_bits = '0;
      endcase
      rd_val = {{(32-GPIO_W){1'b0}}, rd_bits};
   end

   always_ff @(posedge iHCLK) begin
      if (iHRESET) begin
         state      <= ACCESS;
         data_q     <= '0;
         dirm_q     <= '0;
         oen_q      <= '0;
         wr_pend    <= 1'b0;
         wr_sel     <= 2'd0;
         oHREADYOUT <= 1'b1;
         oHRESP     <= RESP_OKAY;
         oHRDATA    <= '0;
      end else begin
         data_q  <= data_nx;
         dirm_q  <= dirm_nx;
         oen_q   <= oen_nx;
         wr_pend <= 1'b0;
         case (state)
            ACCESS, ERR2: begin
               if (accept && bad) begin
                  state      <= ERR1;
                  oHREADYOUT <= 1'b0;
                  oHRESP     <= RESP_ERROR;
                  oHRDATA    <= '0;
               end else begin
                  state      <= ACCESS;
                  oHREADYOUT <= 1'b1;
                  oHRESP     <= RESP_OKAY;
                  if (accept) begin
                     wr_pend <= iHWRITE;
                     wr_sel  <= off[3:2];
                     if (!iHWRITE) oHRDATA <= rd_val;
                  end
               end
            end
            ERR1: begin
               state      <= ERR2;
               oHREADYOUT <= 1'b1;
               oHRESP     <= RESP_ERROR;
            end
            default: begin
               state      <= ACCESS;
               oHREADYOUT <= 1'b1;
               oHRESP     <= RESP_OKAY;
            end
         endcase
      end
   end

   assign oGPIO_OUT = data_q;
   assign oGPIO_OE  = dirm_q & oen_q;

   assign unused_ok = ^{iHSIZE, iHTRANS[0], iHADDR[31:8], iHWDATA[31:GPIO_W]};

endmodule

// File: tb/tb_ahb_gpio_slave.sv
// Self-checking bench for ahb_gpio_slave: directed vector table, hand-written corner sequences, random traffic vs. a register-level model.
module tb_ahb_gpio_slave;

   localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10;

   logic        iHCLK, iHRESET, iHSEL, iHWRITE, iHREADY;
   logic [31:0] iHADDR, iHWDATA;
   logic [1:0]  iHTRANS;
   logic [2:0]  iHSIZE;
   logic        oHREADYOUT;
   logic [31:0] oHRDATA;
   logic [1:0]  oHRESP;
   logic [7:0]  iGPIO_IN, oGPIO_OUT, oGPIO_OE;

   ahb_gpio_slave dut (
      .iHCLK(iHCLK), .iHRESET(iHRESET), .iHSEL(iHSEL), .iHADDR(iHADDR),
      .iHTRANS(iHTRANS), .iHWRITE(iHWRITE), .iHSIZE(iHSIZE), .iHWDATA(iHWDATA),
      .iHREADY(iHREADY), .oHREADYOUT(oHREADYOUT), .oHRDATA(oHRDATA), .oHRESP(oHRESP),
      .iGPIO_IN(iGPIO_IN), .oGPIO_OUT(oGPIO_OUT), .oGPIO_OE(oGPIO_OE)
   );

   initial iHCLK = 1'b0;
   always #5 iHCLK = ~iHCLK;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        wr;
      logic [7:0]  off;
      logic [31:0] wdata;
      logic [7:0]  pins;
      logic        err;
      logic [31:0] rdata;
      logic [7:0]  out;
      logic [7:0]  oe;
   } vec_t;

   vec_t tbl [16];

   // Reference model: architectural registers in program order plus pin history per cycle.
   logic [7:0]  m_data, m_dirm, m_oen;
   logic [31:0] last_rd;
   logic        have_wd;
   logic [7:0]  wd_off;
   logic [31:0] wd_val;
   logic [7:0]  pin_hist [$];

   logic        r_sel, r_wr, r_rdy, r_acc, r_err;
   logic [1:0]  r_trans;
   logic [7:0]  r_off;
   logic [31:0] r_wd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clk_step();
      pin_hist.push_back(iGPIO_IN);
      @(posedge iHCLK);
      #1;
   endtask

   task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [7:0] off, input logic [31:0] hwdata);
      iHSEL   = sel;
      iHTRANS = trans;
      iHWRITE = wr;
      iHADDR  = {4'h0, 20'($urandom), off};
      iHSIZE  = 3'($urandom);
      iHWDATA = hwdata;
      iHREADY = 1'b1;
   endtask

   task automatic do_reset();
      iHRESET = 1'b1;
      drive(1'b0, IDLE, 1'b0, 8'h00, 32'h0);
      for (int i = 0; i < 3; i++) clk_step();
      iHRESET = 1'b0;
      m_data = 8'h00; m_dirm = 8'h00; m_oen = 8'h00;
      last_rd = 32'h0; have_wd = 1'b0;
      pin_hist.delete();
      pin_hist.push_back(8'hFF);
      pin_hist.push_back(8'hFF);
   endtask

   function automatic logic mapped(input logic [7:0] off);
      return off == 8'h00 || off == 8'h04 || off == 8'h08 || off == 8'h0C;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] off, input logic [7:0] pins);
      logic [7:0] v;
      v = 8'h00;
      if (off == 8'h00) v = pins;
      else if (off == 8'h08) v = m_dirm;
      else if (off == 8'h0C) v = m_oen;
      else if (off == 8'h04)
         for (int b = 0; b < 8; b++) v[b] = m_dirm[b] ? m_data[b] : pins[b];
      return {24'h0, v};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      iGPIO_IN = 8'hFF;
      iHRESET  = 1'b1;
      drive(1'b0, IDLE, 1'b0, 8'h00, 32'h0);

      //            wr    off    wdata         pins   err   rdata         out    oe
      tbl[0]  = '{1'b0, 8'h08, 32'h0,        8'hFF, 1'b0, 32'h00000000, 8'h00, 8'h00};
      tbl[1]  = '{1'b0, 8'h0C, 32'h0,        8'hFF, 1'b0, 32'h00000000, 8'h00, 8'h00};
      tbl[2]  = '{1'b0, 8'h04, 32'h0,        8'hFF, 1'b0, 32'h000000FF, 8'h00, 8'h00};
      tbl[3]  = '{1'b0, 8'h00, 32'h0,        8'hFF, 1'b0, 32'h000000FF, 8'h00, 8'h00};
      tbl[4]  = '{1'b1, 8'h08, 32'h000000F0, 8'hFF, 1'b0, 32'h0,        8'h00, 8'h00};
      tbl[5]  = '{1'b1, 8'h0C, 32'h000000F0, 8'hFF, 1'b0, 32'h0,        8'h00, 8'hF0};
      tbl[6]  = '{1'b1, 8'h04, 32'h00000050, 8'hFF, 1'b0, 32'h0,        8'h50, 8'hF0};
      tbl[7]  = '{1'b0, 8'h04, 32'h0,        8'h0E, 1'b0, 32'h0000005E, 8'h50, 8'hF0};
      tbl[8]  = '{1'b0, 8'h00, 32'h0,        8'h0E, 1'b0, 32'h0000000E, 8'h50, 8'hF0};
      tbl[9]  = '{1'b1, 8'h00, 32'h00000033, 8'h0E, 1'b1, 32'h00000000, 8'h50, 8'hF0};
      tbl[10] = '{1'b0, 8'h10, 32'h0,        8'h0E, 1'b1, 32'h00000000, 8'h50, 8'hF0};
      tbl[11] = '{1'b1, 8'h10, 32'h000000FF, 8'h0E, 1'b1, 32'h00000000, 8'h50, 8'hF0};
      tbl[12] = '{1'b0, 8'h08, 32'h0,        8'h0E, 1'b0, 32'h000000F0, 8'h50, 8'hF0};
      tbl[13] = '{1'b0, 8'h05, 32'h0,        8'h0E, 1'b1, 32'h00000000, 8'h50, 8'hF0};
      tbl[14] = '{1'b1, 8'h0C, 32'hFFFFFF3C, 8'h0E, 1'b0, 32'h0,        8'h50, 8'h30};
      tbl[15] = '{1'b0, 8'h0C, 32'h0,        8'h0E, 1'b0, 32'h0000003C, 8'h50, 8'h30};

      do_reset();
      chk("reset_readyout", {31'h0, oHREADYOUT}, 32'h1);
      chk("reset_resp", {30'h0, oHRESP}, 32'h0);
      chk("reset_rdata", oHRDATA, 32'h0);
      chk("reset_gpio_out", {24'h0, oGPIO_OUT}, 32'h0);
      chk("reset_gpio_oe", {24'h0, oGPIO_OE}, 32'h0);

      // Directed vectors: pins settle, one transfer, one idle cycle to finish any write.
      for (int v = 0; v < 16; v++) begin
         iGPIO_IN = tbl[v].pins;
         drive(1'b0, IDLE, 1'b0, 8'h00, 32'h0);
         clk_step();
         clk_step();
         drive(1'b1, NONSEQ, tbl[v].wr, tbl[v].off, $urandom);
         clk_step();
         if (tbl[v].err) begin
            chk($sformatf("tbl%0d_err1_ready", v), {31'h0, oHREADYOUT}, 32'h0);
            chk($sformatf("tbl%0d_err1_resp", v), {30'h0, oHRESP}, 32'h1);
            chk($sformatf("tbl%0d_err1_rdata", v), oHRDATA, 32'h0);
            drive(1'b0, IDLE, 1'b0, 8'h00, tbl[v].wdata);
            iHREADY = 1'b0;
            clk_step();
            chk($sformatf("tbl%0d_err2_ready", v), {31'h0, oHREADYOUT}, 32'h1);
            chk($sformatf("tbl%0d_err2_resp", v), {30'h0, oHRESP}, 32'h1);
         end else begin
            chk($sformatf("tbl%0d_ready", v), {31'h0, oHREADYOUT}, 32'h1);
            chk($sformatf("tbl%0d_resp", v), {30'h0, oHRESP}, 32'h0);
            if (!tbl[v].wr) chk($sformatf("tbl%0d_rdata", v), oHRDATA, tbl[v].rdata);
         end
         drive(1'b0, IDLE, 1'b0, 8'h00, tbl[v].wdata);
         clk_step();
         chk($sformatf("tbl%0d_idle_resp", v), {30'h0, oHRESP}, 32'h0);
         chk($sformatf("tbl%0d_gpio_out", v), {24'h0, oGPIO_OUT}, {24'h0, tbl[v].out});
         chk($sformatf("tbl%0d_gpio_oe", v), {24'h0, oGPIO_OE}, {24'h0, tbl[v].oe});
      end

      // Back-to-back write/read forwarding (pins 0x0E).
      iGPIO_IN = 8'h0E;
      drive(1'b1, NONSEQ, 1'b1, 8'h08, 32'h0);          clk_step();
      drive(1'b1, NONSEQ, 1'b1, 8'h04, 32'h000000F0);   clk_step();
      drive(1'b1, NONSEQ, 1'b0, 8'h04, 32'h000000A0);   clk_step();
      chk("fwd_data_rdata", oHRDATA, 32'h000000AE);
      drive(1'b1, NONSEQ, 1'b1, 8'h08, 32'h0);          clk_step();
      chk("fwd_data_out", {24'h0, oGPIO_OUT}, 32'h000000A0);
      drive(1'b1, NONSEQ, 1'b0, 8'h04, 32'h0000000F);   clk_step();
      chk("fwd_dirm_rdata", oHRDATA, 32'h00000000);
      drive(1'b1, NONSEQ, 1'b1, 8'h0C, 32'h0);          clk_step();
      drive(1'b1, NONSEQ, 1'b0, 8'h0C, 32'h000000FF);   clk_step();
      chk("fwd_oen_rdata", oHRDATA, 32'h000000FF);
      drive(1'b0, IDLE, 1'b0, 8'h00, 32'h0);            clk_step();
      chk("fwd_gpio_oe", {24'h0, oGPIO_OE}, 32'h0000000F);
      chk("fwd_gpio_out", {24'h0, oGPIO_OUT}, 32'h000000A0);

      // Reset while in the first error cycle.
      drive(1'b1, NONSEQ, 1'b0, 8'h10, 32'h0);          clk_step();
      chk("rst_err1_ready", {31'h0, oHREADYOUT}, 32'h0);
      iHRESET = 1'b1;
      drive(1'b0, IDLE, 1'b0, 8'h00, 32'h0);            clk_step();
      iHRESET = 1'b0;
      chk("rst_err_ready", {31'h0, oHREADYOUT}, 32'h1);
      chk("rst_err_resp", {30'h0, oHRESP}, 32'h0);
      chk("rst_err_rdata", oHRDATA, 32'h0);
      chk("rst_err_out", {24'h0, oGPIO_OUT}, 32'h0);
      chk("rst_err_oe", {24'h0, oGPIO_OE}, 32'h0);
      drive(1'b1, NONSEQ, 1'b0, 8'h08, 32'h0);          clk_step();
      chk("rst_err_dirm", oHRDATA, 32'h0);
      drive(1'b1, NONSEQ, 1'b0, 8'h0C, 32'h0);          clk_step();
      chk("rst_err_oen", oHRDATA, 32'h0);

      // Pin bit0 falls: DATA_RO shows it on the third consecutive read.
      iGPIO_IN = 8'hFF;
      drive(1'b0, IDLE, 1'b0, 8'h00, 32'h0);
      clk_step();
      clk_step();
      iGPIO_IN = 8'hFE;
      drive(1'b1, NONSEQ, 1'b0, 8'h00, 32'h0);          clk_step();
      chk("sync_read0", oHRDATA, 32'h000000FF);
      clk_step();
      chk("sync_read1", oHRDATA, 32'h000000FF);
      clk_step();
      chk("sync_read2", oHRDATA, 32'h000000FE);

      // Reset in the data phase of a write: the write is dropped.
      drive(1'b1, NONSEQ, 1'b1, 8'h04, 32'h0);          clk_step();
      iHRESET = 1'b1;
      drive(1'b0, IDLE, 1'b0, 8'h00, 32'h000000FF);     clk_step();
      iHRESET = 1'b0;
      chk("rst_abort_out", {24'h0, oGPIO_OUT}, 32'h0);

      // Random traffic against the register model.
      do_reset();
      for (int n = 0; n < 500; n++) begin
         r_sel   = ($urandom_range(7) != 0);
         r_trans = 2'($urandom_range(3));
         r_wr    = 1'($urandom_range(1));
         r_off   = ($urandom_range(9) == 0) ? 8'($urandom) : {4'h0, 2'($urandom_range(3)), 2'b00};
         r_wd    = $urandom;
         r_rdy   = have_wd ? 1'b1 : ($urandom_range(5) != 0);
         if ($urandom_range(3) == 0) iGPIO_IN = 8'($urandom);
         drive(r_sel, r_trans, r_wr, r_off, have_wd ? wd_val : $urandom);
         iHREADY = r_rdy;
         clk_step();
         if (have_wd) begin
            if (wd_off == 8'h04) m_data = wd_val[7:0];
            else if (wd_off == 8'h08) m_dirm = wd_val[7:0];
            else if (wd_off == 8'h0C) m_oen = wd_val[7:0];
            have_wd = 1'b0;
         end
         r_acc = r_sel && r_trans[1] && r_rdy;
         r_err = r_acc && (!mapped(r_off) || (r_wr && r_off == 8'h00));
         if (r_acc && !r_err) begin
            if (r_wr) begin
               have_wd = 1'b1;
               wd_off  = r_off;
               wd_val  = r_wd;
            end else begin
               last_rd = model_read(r_off, pin_hist[pin_hist.size()-3]);
            end
         end
         if (r_err) begin
            last_rd = 32'h0;
            chk("rnd_err1_ready", {31'h0, oHREADYOUT}, 32'h0);
            chk("rnd_err1_resp", {30'h0, oHRESP}, 32'h1);
            chk("rnd_err1_rdata", oHRDATA, 32'h0);
            drive(1'b0, IDLE, 1'b0, 8'h00, $urandom);
            iHREADY = 1'b0;
            clk_step();
            chk("rnd_err2_ready", {31'h0, oHREADYOUT}, 32'h1);
            chk("rnd_err2_resp", {30'h0, oHRESP}, 32'h1);
         end else begin
            chk("rnd_ready", {31'h0, oHREADYOUT}, 32'h1);
            chk("rnd_resp", {30'h0, oHRESP}, 32'h0);
            chk("rnd_rdata", oHRDATA, last_rd);
         end
         chk("rnd_gpio_out", {24'h0, oGPIO_OUT}, {24'h0, m_data});
         chk("rnd_gpio_oe", {24'h0, oGPIO_OE}, {24'h0, m_dirm & m_oen});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
